pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter NSTAGE, default 5, meaning number of pipeline stages; stage 0 = PC, stage NSTAGE-1 = last stage able to request a stall.
REQ-002 SHALL have parameter FLUSH_SRC, default 3, meaning index of the stage that raises branch-redirect flushes (EX).
REQ-003 SHALL have parameter WDOG_LIMIT, default 1024, meaning consecutive stalled cycles before the watchdog fires.
REQ-004 SHALL have parameter CNT_W, default 32, meaning width of the per-stage stall-cycle counters.
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port stall_req  input  NSTAGE  bit k = stage k requests a stall (bit 0 ignored).
REQ-008 SHALL have port flush_req  input  1  single-cycle redirect pulse from stage FLUSH_SRC.
REQ-009 SHALL have port cnt_sel  input  clog2(NSTAGE)  selects the counter shown on cnt_val.
REQ-010 SHALL have port stall_o  output  NSTAGE  bit j = hold stage j register this cycle.
REQ-011 SHALL have port flush_o  output  NSTAGE  bit j = insert bubble into stage j register this cycle.
REQ-012 SHALL have port flush_pend_o  output  1  a flush is held awaiting a downstream stall to clear.
REQ-013 SHALL have port wdog_o  output  1  sticky watchdog timeout.
REQ-014 SHALL have port cnt_val  output  CNT_W  stall-cycle count of stage cnt_sel.

Function
REQ-015 stall_o SHALL be combinational: h = highest set index of stall_req[NSTAGE-1:1]; stall_o[j]=1 for all j<=h, else 0; no request -> all 0.
REQ-016 A flush is "effective" when (flush_req or pending) and h < FLUSH_SRC; then flush_o[j]=1 for 1<=j<=FLUSH_SRC-1 and stall_o bits 0..FLUSH_SRC-1 SHALL be forced 0 that cycle.
REQ-017 flush_req with h >= FLUSH_SRC SHALL set a pending register (FSM IDLE->PEND); flush_o stays 0; flush_pend_o=1 from the next cycle.
REQ-018 FSM PEND->IDLE SHALL occur in the cycle the pending flush becomes effective (flush_o asserted exactly one cycle).
REQ-019 A new flush_req while in PEND SHALL merge (still one flush_o cycle).
REQ-020 flush_req and h < FLUSH_SRC in the same cycle SHALL flush immediately, no PEND entry.
REQ-021 Watchdog counter SHALL increment each cycle stall_o[0]=1, clear on any cycle stall_o[0]=0; reaching WDOG_LIMIT sets wdog_o, sticky until rst.
REQ-022 Counter k SHALL increment (saturating at all-ones) each cycle stall_req[k]=1 and h==k (cycle attributed to highest requester only).
REQ-023 cnt_val SHALL be registered: value of counter cnt_sel as of previous edge; cnt_sel >= NSTAGE returns 0.

Reset
REQ-024 While rst=1 stall_o SHALL be all ones and flush_o all zeros (combinational override).
REQ-025 At a clock edge with rst=1: FSM->IDLE, flush_pend_o=0, wdog_o=0, watchdog count=0, all stall counters=0, cnt_val=0.
REQ-026 rst asserted while PEND SHALL discard the pending flush.

Structure
REQ-027 Shared package SHALL hold the FSM state enum (IDLE, PEND) and the default parameter constants.
REQ-028 Per-stage saturating counter SHALL be one sub-module, sat_cnt, instantiated NSTAGE times by generate.

Verification
REQ-029 stall_req=5'b01000 (EX) -> stall_o=5'b01111, flush_o=0; counter 3 increments by 1 per cycle.
REQ-030 stall_req=5'b10100 -> stall_o=5'b11111; only counter 4 increments.
REQ-031 flush_req pulse, stall_req=0 -> same cycle flush_o=5'b00110, stall_o=0, flush_pend_o stays 0.
REQ-032 flush_req while stall_req=5'b10000 for 3 cycles -> flush_pend_o=1 for 3 cycles, flush_o=5'b00110 for exactly 1 cycle when stall_req drops, then pend 0.
REQ-033 WDOG_LIMIT=4, stall_req[4] held 4 cycles -> wdog_o=1 after 4th edge, stays 1 after stall clears until rst.
REQ-034 rst mid-PEND -> stall_o=5'b11111 during rst; after rst flush_o never asserts, counters and cnt_val read 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and default constants for the pipeline
// stall/flush controller.
//   pc_state_e : flush FSM state (IDLE, PEND)
//   *_DEF      : default parameter values used by pipe_ctrl and pipe_ctrl_if
//   sel_w()    : width of a selector able to index n items (min 1)
package pipe_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } pc_state_e;

  localparam int NSTAGE_DEF     = 5;
  localparam int FLUSH_SRC_DEF  = 3;
  localparam int WDOG_LIMIT_DEF = 1024;
  localparam int CNT_W_DEF      = 32;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: bundle between the pipeline datapath (master) and the
// stall/flush controller (slave).
//   stall_req    : per-stage stall requests (bit 0 unused)
//   flush_req    : single-cycle redirect pulse
//   cnt_sel      : stall counter select
//   stall_o      : per-stage hold
//   flush_o      : per-stage bubble insert
//   flush_pend_o : flush waiting on a downstream stall
//   wdog_o       : sticky stall watchdog
//   cnt_val      : selected stall-cycle count (registered)
interface pipe_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int NSTAGE = NSTAGE_DEF,
  parameter int CNT_W  = CNT_W_DEF
) ();
  localparam int SEL_W = sel_w(NSTAGE);

  logic [NSTAGE-1:0] stall_req;
  logic              flush_req;
  logic [SEL_W-1:0]  cnt_sel;
  logic [NSTAGE-1:0] stall_o;
  logic [NSTAGE-1:0] flush_o;
  logic              flush_pend_o;
  logic              wdog_o;
  logic [CNT_W-1:0]  cnt_val;

  modport master (
    output stall_req, flush_req, cnt_sel,
    input  stall_o, flush_o, flush_pend_o, wdog_o, cnt_val
  );

  modport slave (
    input  stall_req, flush_req, cnt_sel,
    output stall_o, flush_o, flush_pend_o, wdog_o, cnt_val
  );
endinterface

// File: rtl/pipe_ctrl_sat_cnt.sv
// sat_cnt: saturating up-counter, one per pipeline stage.
//   clk, rst : clock, synchronous active-high reset
//   inc_i    : count this cycle
//   cnt_o    : current count, sticks at all-ones
module sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: in-order pipeline stall/flush controller.
//   clk, rst : clock, synchronous active-high reset
//   bus      : pipe_ctrl_if.slave (requests in, hold/bubble/status out)
// The highest stalled stage holds itself and everything upstream. A redirect
// from FLUSH_SRC bubbles stages 1..FLUSH_SRC-1, but only once nothing at or
// beyond FLUSH_SRC is stalled; otherwise it is parked in PEND until then.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NSTAGE     = NSTAGE_DEF,
  parameter int FLUSH_SRC  = FLUSH_SRC_DEF,
  parameter int WDOG_LIMIT = WDOG_LIMIT_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic     clk,
  input  logic     rst,
  pipe_ctrl_if.slave bus
);
  localparam int SEL_W = sel_w(NSTAGE);
  localparam int WD_W  = $clog2(WDOG_LIMIT + 1);

  // Stages 0..FLUSH_SRC-1 lose their hold during a flush; 1..FLUSH_SRC-1 get bubbles.
  localparam logic [NSTAGE-1:0] LOW_MASK   = NSTAGE'((64'd1 << FLUSH_SRC) - 64'd1);
  localparam logic [NSTAGE-1:0] FLUSH_MASK = {LOW_MASK[NSTAGE-1:1], 1'b0};

  pc_state_e          state_q;
  logic [WD_W-1:0]    wd_q;
  logic               wdog_q;
  logic [CNT_W-1:0]   cnt_val_q;

  logic [NSTAGE-1:0]             stall_raw;
  logic                          acc;
  logic                          eff;
  logic [NSTAGE-1:0]             stall_w;
  logic [NSTAGE-1:0]             inc;
  logic [NSTAGE-1:0][CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]              sel_val;

  // stall_raw[j] = some stage >= max(j,1) requests, i.e. h >= j.
  always_comb begin
    stall_raw = '0;
    acc       = 1'b0;
    for (int j = NSTAGE - 1; j >= 0; j--) begin
      if (j >= 1) acc = acc | bus.stall_req[j];
      stall_raw[j] = acc;
    end
  end

  // stall_raw[FLUSH_SRC] set means h >= FLUSH_SRC, so the flush must wait.
  assign eff = (bus.flush_req | (state_q == PEND)) & ~stall_raw[FLUSH_SRC];

  assign stall_w     = rst ? '1 : (eff ? (stall_raw & ~LOW_MASK) : stall_raw);
  assign bus.stall_o = stall_w;
  assign bus.flush_o = (rst || !eff) ? '0 : FLUSH_MASK;

  // Credit the cycle only to the highest requester: no request above k.
  assign inc = bus.stall_req & ~{1'b0, stall_raw[NSTAGE-1:1]} & ~NSTAGE'(1);

  for (genvar g = 0; g < NSTAGE; g++) begin : g_cnt
    sat_cnt #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc_i (inc[g]),
      .cnt_o (cnt[g])
    );
  end

  // Out-of-range selects match no counter and read as zero.
  always_comb begin
    sel_val = '0;
    for (int k = 0; k < NSTAGE; k++)
      if (bus.cnt_sel == SEL_W'(k)) sel_val = cnt[k];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wd_q      <= '0;
      wdog_q    <= 1'b0;
      cnt_val_q <= '0;
    end else begin
      if (state_q == IDLE) begin
        if (bus.flush_req && !eff) state_q <= PEND;
      end else begin
        if (eff) state_q <= IDLE;
      end

      if (stall_w[0]) begin
        if (wd_q != WD_W'(WDOG_LIMIT)) wd_q <= wd_q + 1'b1;
      end else begin
        wd_q <= '0;
      end
      if (stall_w[0] && (wd_q == WD_W'(WDOG_LIMIT - 1))) wdog_q <= 1'b1;

      cnt_val_q <= sel_val;
    end
  end

  assign bus.flush_pend_o = (state_q == PEND);
  assign bus.wdog_o       = wdog_q;
  assign bus.cnt_val      = cnt_val_q;
endmodule
